// File: rtl/snake_pkg.sv
// Shared snake-game types, map geometry and the point-spawn LFSR helpers.
package snake_pkg;

  localparam int unsigned COORD_W    = 5;
  localparam int unsigned MAP_WIDTH  = 32;
  localparam int unsigned MAP_HEIGHT = 24;
  localparam int unsigned X_MIN      = 1;
  localparam int unsigned X_MAX      = 30;
  localparam int unsigned Y_MIN      = 1;
  localparam int unsigned Y_MAX      = 22;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WALL  = 2'd1,
    BODY  = 2'd2,
    FOOD  = 2'd3
  } tile_t;

  typedef enum logic {
    MENU = 1'b0,
    GAME = 1'b1
  } game_mode;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    CHECK    = 3'd2,
    SCAN_REQ = 3'd3,
    SCAN_CHK = 3'd4,
    PLACE    = 3'd5
  } spawn_state_t;

  function automatic coord_t lfsr(input coord_t v);
    return {v[3], v[2], v[1], v[0] ^ v[4], v[4]};
  endfunction

  // (v % 30) + 1; valid because a 5-bit v is below twice the interior width
  function automatic coord_t map_x(input coord_t v);
    return (v >= COORD_W'(X_MAX)) ? v - COORD_W'(X_MAX - X_MIN) : v + COORD_W'(X_MIN);
  endfunction

  // (v % 22) + 1
  function automatic coord_t map_y(input coord_t v);
    return (v >= COORD_W'(Y_MAX)) ? v - COORD_W'(Y_MAX - Y_MIN) : v + COORD_W'(Y_MIN);
  endfunction

endpackage

// File: rtl/spawn_scan_cnt.sv
// Raster counter over the map interior (x fastest) with next-tile and end flag.
module spawn_scan_cnt
  import snake_pkg::*;
(
  input  logic   clk_75,
  input  logic   rst,
  input  logic   clr,
  input  logic   inc,
  output coord_t nx_c,
  output coord_t ny_c,
  output logic   last_c
);

  coord_t x_q, x_d;
  coord_t y_q, y_d;

  always_comb begin
    if (x_q == COORD_W'(X_MAX)) begin
      nx_c = COORD_W'(X_MIN);
      ny_c = y_q + COORD_W'(1);
    end else begin
      nx_c = x_q + COORD_W'(1);
      ny_c = y_q;
    end
    last_c = (x_q == COORD_W'(X_MAX)) && (y_q == COORD_W'(Y_MAX));
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = COORD_W'(X_MIN);
      y_d = COORD_W'(Y_MIN);
    end else if (inc) begin
      x_d = nx_c;
      y_d = ny_c;
    end
  end

  always_ff @(posedge clk_75) begin
    if (rst) begin
      x_q <= COORD_W'(X_MIN);
      y_q <= COORD_W'(Y_MIN);
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/point_spawn_ctrl.sv
// Finds an EMPTY interior tile for the next point: LFSR probes, then a raster scan.
module point_spawn_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned READ_LAT  = 1
) (
  input  logic               clk_75,
  input  logic               rst,
  input  game_mode           mode,
  input  logic [COORD_W-1:0] seed_x,
  input  logic [COORD_W-1:0] seed_y,
  input  logic               start,
  input  logic               eat,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y,
  input  tile_t              rd_tile,
  output logic               place_valid,
  output logic [COORD_W-1:0] place_x,
  output logic [COORD_W-1:0] place_y,
  input  logic               place_ready,
  output logic               busy,
  output logic               no_space
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  spawn_state_t state_q, state_d;
  coord_t       cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  coord_t       last_x_q, last_x_d, last_y_q, last_y_d;
  coord_t       rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  coord_t       place_x_q, place_x_d, place_y_q, place_y_d;
  logic [TRY_W-1:0] tries_q, tries_d, tries_inc;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic         pending_q, pending_d;
  logic         place_valid_q, place_valid_d;
  logic         busy_q, busy_d;
  logic         no_space_q, no_space_d;

  logic         scan_clr, scan_inc, scan_last_c;
  coord_t       scan_nx_c, scan_ny_c;
  logic         launch;
  coord_t       launch_x, launch_y;

  spawn_scan_cnt u_scan (
    .clk_75 (clk_75),
    .rst    (rst),
    .clr    (scan_clr),
    .inc    (scan_inc),
    .nx_c   (scan_nx_c),
    .ny_c   (scan_ny_c),
    .last_c (scan_last_c)
  );

  always_comb begin
    state_d       = state_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    last_x_d      = last_x_q;
    last_y_d      = last_y_q;
    rd_x_d        = rd_x_q;
    rd_y_d        = rd_y_q;
    place_x_d     = place_x_q;
    place_y_d     = place_y_q;
    tries_d       = tries_q;
    lat_d         = lat_q;
    pending_d     = pending_q;
    place_valid_d = place_valid_q;
    no_space_d    = 1'b0;
    scan_clr      = 1'b0;
    scan_inc      = 1'b0;
    launch        = 1'b0;
    launch_x      = cand_x_q;
    launch_y      = cand_y_q;
    tries_inc     = tries_q + TRY_W'(1);

    if (place_valid_q && place_ready) begin
      last_x_d = place_x_q;
      last_y_d = place_y_q;
    end

    if (mode != GAME) begin
      state_d       = IDLE;
      place_valid_d = 1'b0;
      pending_d     = 1'b0;
      tries_d       = '0;
    end else if (start) begin
      launch        = 1'b1;
      launch_x      = map_x(seed_x);
      launch_y      = map_y(seed_y);
      tries_d       = '0;
      pending_d     = 1'b0;
      place_valid_d = 1'b0;
    end else begin
      if (eat && (state_q != IDLE)) pending_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (eat) begin
            launch   = 1'b1;
            launch_x = map_x(lfsr(last_x_q));
            launch_y = map_y(lfsr(last_y_q));
            tries_d  = '0;
          end
        end
        REQ: begin
          if (lat_q == LAT_W'(READ_LAT - 1)) state_d = CHECK;
          else lat_d = lat_q + LAT_W'(1);
        end
        CHECK: begin
          if (rd_tile == EMPTY) begin
            state_d       = PLACE;
            place_valid_d = 1'b1;
            place_x_d     = cand_x_q;
            place_y_d     = cand_y_q;
          end else begin
            tries_d = tries_inc;
            if (tries_inc < TRY_W'(MAX_TRIES)) begin
              launch   = 1'b1;
              launch_x = map_x(lfsr(cand_x_q));
              launch_y = map_y(lfsr(cand_y_q));
            end else begin
              state_d  = SCAN_REQ;
              scan_clr = 1'b1;
              rd_x_d   = COORD_W'(X_MIN);
              rd_y_d   = COORD_W'(Y_MIN);
              lat_d    = '0;
            end
          end
        end
        SCAN_REQ: begin
          if (lat_q == LAT_W'(READ_LAT - 1)) state_d = SCAN_CHK;
          else lat_d = lat_q + LAT_W'(1);
        end
        SCAN_CHK: begin
          if (rd_tile == EMPTY) begin
            state_d       = PLACE;
            place_valid_d = 1'b1;
            place_x_d     = rd_x_q;
            place_y_d     = rd_y_q;
          end else if (scan_last_c) begin
            no_space_d = 1'b1;
            state_d    = IDLE;
            tries_d    = '0;
            pending_d  = 1'b0;
          end else begin
            scan_inc = 1'b1;
            rd_x_d   = scan_nx_c;
            rd_y_d   = scan_ny_c;
            state_d  = SCAN_REQ;
            lat_d    = '0;
          end
        end
        PLACE: begin
          if (place_ready) begin
            place_valid_d = 1'b0;
            // a queued eat chains straight into the next search from this placement
            if (pending_q || eat) begin
              pending_d = 1'b0;
              tries_d   = '0;
              launch    = 1'b1;
              launch_x  = map_x(lfsr(place_x_q));
              launch_y  = map_y(lfsr(place_y_q));
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (launch) begin
      state_d  = REQ;
      cand_x_d = launch_x;
      cand_y_d = launch_y;
      rd_x_d   = launch_x;
      rd_y_d   = launch_y;
      lat_d    = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_75) begin
    if (rst) begin
      state_q       <= IDLE;
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      last_x_q      <= COORD_W'(X_MIN);
      last_y_q      <= COORD_W'(Y_MIN);
      rd_x_q        <= '0;
      rd_y_q        <= '0;
      place_x_q     <= '0;
      place_y_q     <= '0;
      tries_q       <= '0;
      lat_q         <= '0;
      pending_q     <= 1'b0;
      place_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      no_space_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      last_x_q      <= last_x_d;
      last_y_q      <= last_y_d;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
      place_x_q     <= place_x_d;
      place_y_q     <= place_y_d;
      tries_q       <= tries_d;
      lat_q         <= lat_d;
      pending_q     <= pending_d;
      place_valid_q <= place_valid_d;
      busy_q        <= busy_d;
      no_space_q    <= no_space_d;
    end
  end

  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign place_valid = place_valid_q;
  assign place_x     = place_x_q;
  assign place_y     = place_y_q;
  assign busy        = busy_q;
  assign no_space    = no_space_q;

endmodule

// File: tb/tb_point_spawn_ctrl.sv
// Directed bench for point_spawn_ctrl with a one-cycle-latency tile map model.
`timescale 1ns/1ps
module tb_point_spawn_ctrl;
  import snake_pkg::*;

  logic       clk_75 = 1'b0;
  logic       rst;
  game_mode   mode;
  logic [4:0] seed_x, seed_y;
  logic       start, eat, place_ready;
  tile_t      rd_tile;
  logic [4:0] rd_x, rd_y, place_x, place_y;
  logic       place_valid, busy, no_space;

  int errors = 0;
  int checks = 0;
  int tile_cfg = 0;
  int addr_log[$];
  int prev_addr = -1;
  int saved_addr = 0;

  point_spawn_ctrl #(.MAX_TRIES(8), .READ_LAT(1)) dut (
    .clk_75      (clk_75),
    .rst         (rst),
    .mode        (mode),
    .seed_x      (seed_x),
    .seed_y      (seed_y),
    .start       (start),
    .eat         (eat),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_tile     (rd_tile),
    .place_valid (place_valid),
    .place_x     (place_x),
    .place_y     (place_y),
    .place_ready (place_ready),
    .busy        (busy),
    .no_space    (no_space)
  );

  always #5 clk_75 = ~clk_75;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // 0: all EMPTY, 1: all WALL, 2: only (5,2) EMPTY, 3: only (8,6) blocked
  function automatic tile_t tile_at(input int a);
    int x;
    int y;
    x = a / 32;
    y = a % 32;
    case (tile_cfg)
      0: return EMPTY;
      1: return WALL;
      2: return (x == 5 && y == 2) ? EMPTY : WALL;
      default: return (x == 8 && y == 6) ? BODY : EMPTY;
    endcase
  endfunction

  function automatic int log_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : -1;
  endfunction

  // map model (address in cycle n -> tile in cycle n+1) and read-address log
  initial begin
    rd_tile = WALL;
    forever begin
      @(posedge clk_75);
      #1;
      rd_tile = tile_at(saved_addr);
      saved_addr = int'(rd_x) * 32 + int'(rd_y);
      if (saved_addr != prev_addr) begin
        addr_log.push_back(saved_addr);
        prev_addr = saved_addr;
      end
    end
  end

  task automatic tick;
    @(posedge clk_75);
    #2;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (place_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake;
    place_ready = 1'b1;
    tick();
    place_ready = 1'b0;
  endtask

  task automatic reset_dut;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    addr_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int extra;
    bit seen;
    int pl[$];
    int probe_exp[8];
    probe_exp = '{8*32+6, 17*32+13, 2*32+5, 5*32+11, 11*32+1, 23*32+3, 14*32+7, 29*32+15};

    rst = 1'b1; mode = MENU; seed_x = '0; seed_y = '0;
    start = 1'b0; eat = 1'b0; place_ready = 1'b0;
    tick(); tick();
    chk("rst_place_valid", place_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_no_space", no_space, 0);
    chk("rst_rd_x", rd_x, 0);
    chk("rst_rd_y", rd_y, 0);
    chk("rst_place_x", place_x, 0);
    chk("rst_place_y", place_y, 0);
    rst = 1'b0; mode = GAME;
    tick();

    // start from seeds (7,5), all tiles EMPTY, late ready
    seed_x = 5'd7; seed_y = 5'd5; tile_cfg = 0;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(20, n);
    chk("seed_latency", n, 2);
    chk("seed_place_x", place_x, 8);
    chk("seed_place_y", place_y, 6);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", place_valid, 1);
      chk("hold_x", place_x, 8);
      chk("hold_y", place_y, 6);
    end
    handshake();
    chk("valid_fall", place_valid, 0);
    chk("idle_after_place", busy, 0);

    // eat from last=(8,6)
    addr_log.delete();
    eat = 1'b1; tick(); eat = 1'b0;
    wait_valid(20, n);
    chk("eat_latency", n, 2);
    chk("eat_first_probe", log_at(0), 17*32+13);
    chk("eat_place_x", place_x, 17);
    chk("eat_place_y", place_y, 13);
    handshake();

    // reset in the middle of a scan, with an eat pending
    tile_cfg = 1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (30) tick();
    chk("scan_busy", busy, 1);
    eat = 1'b1; tick(); eat = 1'b0;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_place_valid", place_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_no_space", no_space, 0);
    chk("mid_rst_rd", int'(rd_x) * 32 + int'(rd_y), 0);
    chk("mid_rst_place", int'(place_x) * 32 + int'(place_y), 0);
    tile_cfg = 0;
    repeat (4) tick();
    chk("mid_rst_pending_clear", busy, 0);
    addr_log.delete();
    eat = 1'b1; tick(); eat = 1'b0;
    wait_valid(20, n);
    chk("rst_last_probe", log_at(0), 3*32+3);
    chk("rst_last_place", int'(place_x) * 32 + int'(place_y), 3*32+3);
    handshake();

    // 8 failed probes then a raster scan finding (5,2)
    reset_dut();
    tile_cfg = 2; seed_x = 5'd7; seed_y = 5'd5;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(200, n);
    chk("scan_latency", n, 86);
    chk("scan_place_x", place_x, 5);
    chk("scan_place_y", place_y, 2);
    chk("scan_reads", addr_log.size(), 43);
    for (int i = 0; i < 8; i++) chk("probe_seq", log_at(i), probe_exp[i]);
    chk("scan_first_tile", log_at(8), 1*32+1);
    chk("scan_last_tile", log_at(42), 5*32+2);
    handshake();

    // map full: one no_space pulse after (30,22), last stays (5,2)
    tile_cfg = 1;
    start = 1'b1; tick(); start = 1'b0;
    n = 0; seen = 0;
    while (no_space !== 1'b1 && n < 2000) begin
      tick();
      n++;
      if (place_valid === 1'b1) seen = 1;
    end
    chk("full_latency", n, 1336);
    chk("full_busy_drop", busy, 0);
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (no_space === 1'b1) extra++;
      if (place_valid === 1'b1) seen = 1;
    end
    chk("full_single_pulse", extra, 0);
    chk("full_no_place", seen, 0);
    tile_cfg = 0;
    eat = 1'b1; tick(); eat = 1'b0;
    wait_valid(20, n);
    chk("full_last_kept", int'(place_x) * 32 + int'(place_y), 11*32+5);
    handshake();

    // eats during search and during PLACE -> two placements, chained
    tile_cfg = 3; seed_x = 5'd7; seed_y = 5'd5;
    start = 1'b1; tick(); start = 1'b0;
    eat = 1'b1; tick(); eat = 1'b0;
    tick();
    eat = 1'b1; tick(); eat = 1'b0;
    wait_valid(20, n);
    eat = 1'b1; tick(); eat = 1'b0;
    place_ready = 1'b1;
    pl.delete();
    for (int i = 0; i < 40; i++) begin
      if (place_valid === 1'b1) pl.push_back(int'(place_x) * 32 + int'(place_y));
      tick();
    end
    place_ready = 1'b0;
    chk("pend_count", pl.size(), 2);
    chk("pend_first", (pl.size() > 0) ? pl[0] : -1, 17*32+13);
    chk("pend_second", (pl.size() > 1) ? pl[1] : -1, 2*32+5);
    chk("pend_idle", busy, 0);

    // start and eat together, seeds at the top of the 5-bit range
    tile_cfg = 0; seed_x = 5'd31; seed_y = 5'd31;
    start = 1'b1; eat = 1'b1; tick(); start = 1'b0; eat = 1'b0;
    wait_valid(20, n);
    chk("start_wins_x", place_x, 2);
    chk("start_wins_y", place_y, 10);
    handshake();
    repeat (6) tick();
    chk("eat_dropped", busy, 0);

    // leave GAME while a placement is offered
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(20, n);
    chk("menu_pre_valid", place_valid, 1);
    mode = MENU; tick();
    chk("menu_valid_drop", place_valid, 0);
    chk("menu_busy", busy, 0);
    mode = GAME; tick();
    chk("menu_stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
